// File: rtl/bcd_convert_arbiter_if.sv
// Requester and converter signals for the shared BCD converter arbiter.
// slave is the arbiter side, master is the requester/converter side.
`timescale 1ns/1ps
interface bcd_convert_arbiter_if #(
    parameter int INPUT_WIDTH    = 7,
    parameter int DECIMAL_DIGITS = 2,
    parameter int NUM_REQ        = 3
);
    logic [NUM_REQ-1:0]             i_Req;
    logic [NUM_REQ*INPUT_WIDTH-1:0] i_Binary;
    logic [NUM_REQ-1:0]             o_Grant;
    logic [NUM_REQ-1:0]             o_Done;
    logic                           o_Error;
    logic [DECIMAL_DIGITS*4-1:0]    o_BCD;
    logic                           o_Busy;
    logic                           o_Conv_Start;
    logic [INPUT_WIDTH-1:0]         o_Conv_Binary;
    logic                           i_Conv_Done;
    logic [DECIMAL_DIGITS*4-1:0]    i_Conv_BCD;

    modport slave (
        input  i_Req, i_Binary, i_Conv_Done, i_Conv_BCD,
        output o_Grant, o_Done, o_Error, o_BCD,
        output o_Busy, o_Conv_Start, o_Conv_Binary
    );

    modport master (
        output i_Req, i_Binary, i_Conv_Done, i_Conv_BCD,
        input  o_Grant, o_Done, o_Error, o_BCD,
        input  o_Busy, o_Conv_Start, o_Conv_Binary
    );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Round-robin sharing of one sequential binary-to-BCD converter
// between several requesters, with a watchdog on each conversion.
`timescale 1ns/1ps
module bcd_convert_arbiter #(
    parameter int INPUT_WIDTH    = 7,
    parameter int DECIMAL_DIGITS = 2,
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_Clock,
    input  logic i_Reset,
    bcd_convert_arbiter_if.slave bus
);
    localparam int BW = DECIMAL_DIGITS * 4;
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE, START, WAIT, RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   err_q, err_d;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic                   busy_q, busy_d;
    logic                   start_q, start_d;
    logic [INPUT_WIDTH-1:0] bin_q, bin_d;

    logic                   win_vld;
    logic [IW-1:0]          win_idx;

    // First asserted request at or above the pointer, wrapping to 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_vld && bus.i_Req[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = err_q;
        bcd_d   = bcd_q;
        start_d = 1'b0;
        bin_d   = bin_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    idx_d   = win_idx;
                    bin_d   = bus.i_Binary[win_idx*INPUT_WIDTH +: INPUT_WIDTH];
                    grant_d = NUM_REQ'(1) << win_idx;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done on the terminal count still counts as success.
                if (bus.i_Conv_Done) begin
                    bcd_d   = bus.i_Conv_BCD;
                    err_d   = 1'b0;
                    done_d  = grant_q;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    bcd_d   = '0;
                    err_d   = 1'b1;
                    done_d  = grant_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                grant_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            bin_q   <= bin_d;
        end
    end

    assign bus.o_Grant       = grant_q;
    assign bus.o_Done        = done_q;
    assign bus.o_Error       = err_q;
    assign bus.o_BCD         = bcd_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Conv_Start  = start_q;
    assign bus.o_Conv_Binary = bin_q;
endmodule

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
- Shares one sequential binary-to-BCD converter between NUM_REQ requesters, for example several display channels feeding one converter.
- Arbitrates round-robin, captures the winner's operand, issues a one-cycle start and waits for the converter's done. It then returns the BCD result with a one-cycle done pulse to the winner.
- A watchdog aborts a conversion that never completes and flags an error.

Parameters:
- INPUT_WIDTH, 7, width of each binary operand.
- DECIMAL_DIGITS, 2, number of BCD digits in the result.
- NUM_REQ, 3, number of requesters (at least 2).
- TIMEOUT_CYCLES, 64, maximum number of WAIT cycles before an abort (at least 2).

Ports:
- i_Clock  in  1  system clock; all logic is on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester conversion request (level).
- i_Binary  in  NUM_REQ*INPUT_WIDTH  operands; requester k uses slice [k*INPUT_WIDTH +: INPUT_WIDTH].
- o_Grant  out  NUM_REQ  one-hot; high from capture until the end of RESP.
- o_Done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- o_Error  out  1  timeout flag; valid only while o_Done is nonzero.
- o_BCD  out  DECIMAL_DIGITS*4  result; holds its value until the next RESP.
- o_Busy  out  1  high in any state other than IDLE.
- o_Conv_Start  out  1  one-cycle start pulse to the converter.
- o_Conv_Binary  out  INPUT_WIDTH  captured operand to the converter.
- i_Conv_Done  in  1  converter completion strobe.
- i_Conv_BCD  in  DECIMAL_DIGITS*4  converter result; sampled when i_Conv_Done is high.

Behaviour:
- Reset (asynchronous):
  - State = IDLE and round-robin pointer = 0.
  - o_Grant, o_Done, o_Error, o_BCD, o_Busy, o_Conv_Start and o_Conv_Binary all = 0.
  - Asserting reset mid-transaction aborts it with no o_Done.
  - The converter shares i_Reset, so no stale done can survive reset.
- All outputs are registered; they are Moore functions of state and captured registers.
- IDLE:
  - If i_Req is nonzero, select the first asserted bit scanning upward from the pointer, wrapping at NUM_REQ-1 back to 0.
  - On that edge: latch the index, latch the winner's operand into o_Conv_Binary, set o_Grant to that bit, go to START.
  - If i_Req is zero, stay in IDLE.
- START: o_Conv_Start = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - o_Conv_Binary is held constant.
  - If i_Conv_Done is high: latch i_Conv_BCD into o_BCD, set o_Error = 0, go to RESP.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: set o_BCD = 0, set o_Error = 1, go to RESP.
  - Otherwise, increment the counter.
  - If i_Conv_Done and the timeout terminal count occur in the same cycle, done wins.
- RESP:
  - o_Done[idx] = 1 for this cycle only.
  - On exit: pointer = (idx+1) mod NUM_REQ, o_Grant = 0, o_Error = 0, go to IDLE.
- i_Conv_Done outside WAIT is ignored.
- Request rules:
  - Requesters must hold i_Req until their o_Done.
  - A request dropped after capture does not cancel the transaction; o_Done still pulses.
  - Changes to a requester's i_Binary after capture are ignored.
  - A requester that still asserts i_Req after its done is re-arbitrated from the advanced pointer, so it loses to any other pending requester.
- Latency: with a converter that raises done D cycles after the start cycle:
  - Request sampled at edge 0.
  - START occupies cycle 1.
  - o_Done is high in cycle D+2.
  - At least one IDLE cycle separates transactions.
- Fairness: any continuously asserted request is served within NUM_REQ transactions.

Test Plan:
1. Reset, then i_Req=001 with requester 0 operand = 7'd93.
   -> o_Grant=001 after one edge, then a one-cycle o_Conv_Start with o_Conv_Binary=93.
   -> Converter model (D=16) returns 8'h93; o_Done=001 for one cycle, o_BCD=8'h93, o_Error=0.
2. i_Req=111 held continuously, operands 10, 45, 127 (requesters 0, 1, 2).
   -> Grants in order 001, 010, 100, 001.
   -> o_BCD = 8'h10, 8'h45, then 8'h27 (three-digit value truncated to 2 digits).
   -> Exactly one IDLE cycle between each RESP and the next START.
3. Converter model never raises done.
   -> After TIMEOUT_CYCLES=64 WAIT cycles: o_Done pulses with o_Error=1 and o_BCD=0.
   -> The pointer advances and the next request is served normally.
4. i_Conv_Done on the terminal timeout cycle -> o_Error=0 and o_BCD = model value.
   Spurious i_Conv_Done during IDLE -> no state change and no o_Done.
5. Requester 1 drops i_Req and changes its operand from 50 to 99 during WAIT.
   -> o_Done=010 still pulses with o_BCD=8'h50.
6. Assert i_Reset for one cycle during WAIT.
   -> All outputs go to 0 immediately with no o_Done.
   -> After release, pending i_Req=100 is granted first via the pointer reset to 0 scan (requester 2 is the only one pending).
